// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-subset core: IDLE/DECODE/EXEC/MEM/WB FSM with its own register file, data memory and PC.
// Define ADDI_EN to decode opcode 001000 as addi; otherwise that opcode is reported as illegal.
module multicycle_mips_core #(
    parameter int          NREGS      = 32,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] PC_RESET   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  op,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  alu_op,
    output logic [31:0] mem_addr,
    output logic [31:0] alu_result,
    output logic [31:0] pc,
    output logic        done,
    output logic        err,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_sel,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata
);
    localparam int RW = $clog2(NREGS);
    localparam int MW = $clog2(DMEM_DEPTH);

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_J    = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];
    logic [31:0] dmem [DMEM_DEPTH];

    logic [2:0]    dec_op;
    logic [1:0]    dec_alu_op;
    logic [31:0]   imm_sext, alu_b, alu_out, exec_addr, pc4, next_pc, wb_data;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx, wb_idx, dbg_idx;
    logic [MW-1:0] mem_idx;

    assign imm_sext  = {{16{instr_q[15]}}, instr_q[15:0]};
    assign rs_idx    = instr_q[21 +: RW];
    assign rt_idx    = instr_q[16 +: RW];
    assign rd_idx    = instr_q[11 +: RW];
    assign dbg_idx   = dbg_sel[RW-1:0];
    assign mem_idx   = addr_q[MW+1:2];
    assign pc4       = pc_q + 32'd4;
    assign exec_addr = a_q + imm_sext;
    assign wb_idx    = (op_q == OP_R) ? rd_idx : rt_idx;
    assign wb_data   = (op_q == OP_LW) ? mdr_q : alu_q;

    assign pc         = pc_q;
    assign op         = (state_q == S_DECODE) ? dec_op : op_q;
    assign alu_op     = (state_q == S_DECODE) ? dec_alu_op : alu_op_q;
    assign mem_addr   = (state_q == S_EXEC) ? exec_addr : addr_q;
    assign alu_result = (state_q == S_EXEC) ? alu_out : alu_q;
    assign dbg_rdata  = regs_q[dbg_idx];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_op     = OP_ILL;
        dec_alu_op = 2'b00;
        unique case (instr_q[31:26])
            6'b000000: begin
                if (instr_q[5:0] inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
                    dec_op     = OP_R;
                    dec_alu_op = 2'b10;
                end
            end
            6'b100011: dec_op = OP_LW;
            6'b101011: dec_op = OP_SW;
            6'b000100: begin
                dec_op     = OP_BEQ;
                dec_alu_op = 2'b01;
            end
            6'b000010: dec_op = OP_J;
`ifdef ADDI_EN
            6'b001000: dec_op = OP_ADDI;
`endif
            default: ;
        endcase
    end

    always_comb begin
        alu_b = (op_q == OP_R || op_q == OP_BEQ) ? b_q : imm_sext;
        case (alu_op_q)
            2'b00: alu_out = a_q + alu_b;
            2'b01: alu_out = a_q - alu_b;
            2'b10: begin
                case (instr_q[5:0])
                    6'b100000: alu_out = a_q + alu_b;
                    6'b100010: alu_out = a_q - alu_b;
                    6'b100100: alu_out = a_q & alu_b;
                    6'b100101: alu_out = a_q | alu_b;
                    6'b101010: alu_out = {31'd0, $signed(a_q) < $signed(alu_b)};
                    default:   alu_out = 32'd0;
                endcase
            end
            default: alu_out = 32'd0;
        endcase
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (instr_valid) state_d = S_DECODE;
            S_DECODE: state_d = (dec_op == OP_ILL) ? S_IDLE : S_EXEC;
            S_EXEC: begin
                if (op_q == OP_R || op_q == OP_ADDI)     state_d = S_WB;
                else if (op_q == OP_LW || op_q == OP_SW) state_d = S_MEM;
                else                                     state_d = S_IDLE;
            end
            S_MEM:   state_d = (op_q == OP_LW) ? S_WB : S_IDLE;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            S_IDLE:   instr_ready = 1'b1;
            S_DECODE: if (dec_op == OP_ILL) begin
                done = 1'b1;
                err  = 1'b1;
            end
            S_EXEC:   done = (op_q == OP_BEQ || op_q == OP_J);
            S_MEM: begin
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                done      = (op_q == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        next_pc = pc4;
        if (state_q == S_EXEC && op_q == OP_BEQ && a_q == b_q) next_pc = pc4 + (imm_sext << 2);
        else if (state_q == S_EXEC && op_q == OP_J)            next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
    end

    always_comb begin
        pc_d     = done ? next_pc : pc_q;
        instr_d  = instr_q;
        op_d     = op_q;
        alu_op_d = alu_op_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        addr_d   = addr_q;
        mdr_d    = mdr_q;
        case (state_q)
            S_IDLE: if (instr_valid) instr_d = instr;
            S_DECODE: begin
                op_d     = dec_op;
                alu_op_d = dec_alu_op;
                a_d      = regs_q[rs_idx];
                b_d      = regs_q[rt_idx];
            end
            S_EXEC: begin
                alu_d  = alu_out;
                addr_d = exec_addr;
            end
            S_MEM:   mdr_d = dmem[mem_idx];
            default: ;
        endcase
    end

    // A debug write at the accept edge lands before DECODE reads the operands.
    always_comb begin
        regs_d = regs_q;
        if (state_q == S_IDLE && dbg_we && dbg_idx != '0) regs_d[dbg_idx] = dbg_wdata;
        else if (reg_write && wb_idx != '0)               regs_d[wb_idx]  = wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= PC_RESET;
            instr_q  <= '0;
            op_q     <= '0;
            alu_op_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            addr_q   <= '0;
            mdr_q    <= '0;
            regs_q   <= '{default: '0};
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            op_q     <= op_d;
            alu_op_q <= alu_op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            addr_q   <= addr_d;
            mdr_q    <= mdr_d;
            regs_q   <= regs_d;
        end
    end

    // NOTE: data memory has no reset; rst only blocks a store in the cycle it is asserted.
    always_ff @(posedge clk) begin
        if (mem_write && !rst) dmem[mem_idx] <= b_q;
    end
endmodule

// File: tb/tb_multicycle_mips_core.sv
// Scoreboard bench for multicycle_mips_core: driver queues expected completions, a monitor checks each done pulse.
module tb_multicycle_mips_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic        reg_write, mem_read, mem_write;
    logic [1:0]  alu_op;
    logic [31:0] mem_addr, alu_result, pc;
    logic        done, err;
    logic        dbg_we;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_wdata, dbg_rdata;

    multicycle_mips_core dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
        .mem_addr(mem_addr), .alu_result(alu_result), .pc(pc), .done(done), .err(err),
        .dbg_we(dbg_we), .dbg_sel(dbg_sel), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        err;
        int          lat;
        logic [31:0] pc;
        int          nrw, nmr, nmw;
        bit          chk_addr;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_alu_op(input logic [2:0] o);
        case (o)
            3'b000:  return 2'b10;
            3'b011:  return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Monitor
    bit          acc_q, rst_seen, inflight, pc_pend;
    int          cyc, crw, cmr, cmw;
    logic [31:0] pc_exp;
    string       pc_name;

    always @(posedge clk) begin
        acc_q    <= instr_valid && instr_ready && !rst;
        rst_seen <= rst;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (pc_pend) begin
            check({pc_name, ".pc"}, pc, pc_exp);
            pc_pend = 0;
        end
        if (rst_seen) begin
            inflight = 0;
            sb.delete();
        end else begin
            if (acc_q) begin
                inflight = 1;
                cyc = 0; crw = 0; cmr = 0; cmw = 0;
            end
            if (inflight) begin
                cyc++;
                crw += int'(reg_write);
                cmr += int'(mem_read);
                cmw += int'(mem_write);
                check("busy.instr_ready", 32'(instr_ready), 32'd0);
                if (done) begin
                    inflight = 0;
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done: got done with empty queue, expected no done");
                    end else begin
                        e = sb.pop_front();
                        check({e.name, ".op"},      32'(op), 32'(e.op));
                        check({e.name, ".alu_op"},  32'(alu_op), 32'(exp_alu_op(e.op)));
                        check({e.name, ".err"},     32'(err), 32'(e.err));
                        check({e.name, ".latency"}, cyc, e.lat);
                        check({e.name, ".n_reg_write"}, crw, e.nrw);
                        check({e.name, ".n_mem_read"},  cmr, e.nmr);
                        check({e.name, ".n_mem_write"}, cmw, e.nmw);
                        if (e.chk_addr) check({e.name, ".mem_addr"}, mem_addr, e.addr);
                        pc_exp  = e.pc;
                        pc_name = e.name;
                        pc_pend = 1;
                    end
                end
            end else if (done) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_done: got done=1 while idle, expected 0");
            end
        end
    end

    // Driver
    task automatic dbg_wr(input logic [4:0] sel, input logic [31:0] val);
        @(negedge clk);
        dbg_we = 1'b1; dbg_sel = sel; dbg_wdata = val;
        @(negedge clk);
        dbg_we = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] sel, input logic [31:0] exp);
        @(negedge clk);
        dbg_sel = sel;
        #1;
        check(name, dbg_rdata, exp);
    endtask

    // dmode: 0 none, 1 debug write on the accept cycle, 2 debug write during DECODE
    task automatic issue(input string name, input logic [31:0] ins, input logic [2:0] eop, input logic eerr,
                         input int lat, input logic [31:0] npc, input int nrw, input int nmr, input int nmw,
                         input bit chk, input logic [31:0] addr,
                         input int dmode, input logic [4:0] dsel, input logic [31:0] dval);
        bit got;
        sb.push_back('{name, eop, eerr, lat, npc, nrw, nmr, nmw, chk, addr});
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        if (dmode == 1) begin dbg_we = 1'b1; dbg_sel = dsel; dbg_wdata = dval; end
        @(negedge clk);
        instr_valid = 1'b0;
        dbg_we = (dmode == 2);
        if (dmode == 2) begin dbg_sel = dsel; dbg_wdata = dval; end
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin got = 1; break; end
            @(negedge clk);
            dbg_we = 1'b0;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.timeout: got no done in 8 cycles, expected done at cycle %0d", name, lat);
        end
        @(negedge clk);
        dbg_we = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1);
    end

    initial begin : stim
        bit got;
        rst = 1'b1; instr = '0; instr_valid = 1'b0;
        dbg_we = 1'b0; dbg_sel = '0; dbg_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dbg_sel = 5'd5;
        #1;
        check("reset.pc",          pc, 32'h0);
        check("reset.instr_ready", 32'(instr_ready), 32'd1);
        check("reset.op",          32'(op), 32'd0);
        check("reset.alu_op",      32'(alu_op), 32'd0);
        check("reset.strobes",     32'({reg_write, mem_read, mem_write, done, err}), 32'd0);
        check("reset.mem_addr",    mem_addr, 32'h0);
        check("reset.alu_result",  alu_result, 32'h0);
        check("reset.reg5",        dbg_rdata, 32'h0);
        rst = 1'b0;

        dbg_wr(5'd17, 32'd8);
        issue("add", 32'h02328020, 3'b000, 1'b0, 3, 32'd4, 1, 0, 0, 0, 0, 1, 5'd18, 32'd4);
        chk_reg("add.reg16", 5'd16, 32'd12);
        chk_reg("add.reg18", 5'd18, 32'd4);
        issue("sw", 32'hAE300020, 3'b010, 1'b0, 3, 32'd8, 0, 0, 1, 1, 32'd40, 0, 0, 0);
        issue("lw", 32'h8E330020, 3'b001, 1'b0, 4, 32'd12, 1, 1, 0, 1, 32'd40, 0, 0, 0);
        chk_reg("lw.reg19", 5'd19, 32'd12);
        issue("beq_nt", 32'h121100C8, 3'b011, 1'b0, 2, 32'd16, 0, 0, 0, 0, 0, 0, 0, 0);
        dbg_wr(5'd17, 32'd12);
        issue("beq_t", 32'h121100C8, 3'b011, 1'b0, 2, 32'd820, 0, 0, 0, 0, 0, 0, 0, 0);
        issue("j", 32'h080003E8, 3'b100, 1'b0, 2, 32'h00000FA0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue("bad_funct", 32'h02328000, 3'b111, 1'b1, 1, 32'd4004, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("bad_funct.reg16", 5'd16, 32'd12);
        issue("add_r0", 32'h02320020, 3'b000, 1'b0, 3, 32'd4008, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("add_r0.reg0", 5'd0, 32'd0);
`ifdef ADDI_EN
        issue("addi_r0", 32'h20000005, 3'b101, 1'b0, 3, 32'd4012, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("addi_r0.reg0", 5'd0, 32'd0);
        issue("addi", 32'h2234FFFF, 3'b101, 1'b0, 3, 32'd4016, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("addi.reg20", 5'd20, 32'd11);
`else
        issue("addi_r0", 32'h20000005, 3'b111, 1'b1, 1, 32'd4012, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("addi_r0.reg0", 5'd0, 32'd0);
        issue("addi", 32'h2234FFFF, 3'b111, 1'b1, 1, 32'd4016, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("addi.reg20", 5'd20, 32'd0);
`endif
        issue("sub", 32'h02328022, 3'b000, 1'b0, 3, 32'd4020, 1, 0, 0, 0, 0, 2, 5'd21, 32'h0000DEAD);
        chk_reg("sub.reg16", 5'd16, 32'd8);
        chk_reg("dbg_busy.reg21", 5'd21, 32'd0);
        dbg_wr(5'd18, 32'hFFFFFFFF);
        issue("and", 32'h02328024, 3'b000, 1'b0, 3, 32'd4024, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("and.reg16", 5'd16, 32'd12);
        issue("slt_f", 32'h0232802A, 3'b000, 1'b0, 3, 32'd4028, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("slt_f.reg16", 5'd16, 32'd0);
        issue("slt_t", 32'h0251802A, 3'b000, 1'b0, 3, 32'd4032, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_reg("slt_t.reg16", 5'd16, 32'd1);

        // Reset while the store sits in MEM: the word at 40 must keep its old value.
        dbg_wr(5'd16, 32'd99);
        dbg_wr(5'd17, 32'd8);
        sb.push_back('{"sw_rst", 3'b010, 1'b0, 3, 32'h0, 0, 0, 1, 1'b1, 32'd40});
        @(negedge clk);
        instr = 32'hAE300020; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_write) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL sw_rst.timeout: got no mem_write in 8 cycles, expected one");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst.instr_ready", 32'(instr_ready), 32'd1);
        check("rst.pc",          pc, 32'h0);
        chk_reg("rst.reg16", 5'd16, 32'd0);
        dbg_wr(5'd17, 32'd8);
        issue("lw_after_rst", 32'h8E330020, 3'b001, 1'b0, 4, 32'd4, 1, 1, 0, 1, 32'd40, 0, 0, 0);
        chk_reg("lw_after_rst.reg19", 5'd19, 32'd12);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
